wb_trace_recorder: RTL and testbench



---
 rtl/wb_trace_pkg.sv | 21 ++
 rtl/wb_trace_recorder_ram.sv | 27 ++
 rtl/wb_trace_recorder.sv | 157 +++++++++++++++
 tb/tb_wb_trace_recorder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_pkg.sv
// Shared definitions for the write-back trace recorder.
// State encodings and the packed entry layout {pc, reg, value}.
package wb_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_t;

    localparam int PC_W    = 32;
    localparam int REG_W   = 5;
    localparam int VAL_W   = 32;
    localparam int ENTRY_W = PC_W + REG_W + VAL_W;

    localparam int VAL_LSB = 0;
    localparam int REG_LSB = VAL_W;
    localparam int PC_LSB  = VAL_W + REG_W;

endpackage

// File: rtl/wb_trace_recorder_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port.
// The array carries no reset; validity is tracked by the recorder's count.
import wb_trace_pkg::*;

module trace_ram #(
    parameter int DEPTH = 16,
    parameter int W     = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_recorder.sv
// Write-back trace recorder: circular capture, PC trigger, post-trigger
// window, then oldest-first drain over a valid/ready port.
import wb_trace_pkg::*;

module wb_trace_recorder #(
    parameter int DEPTH     = 16,
    parameter int FILTER_X0 = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     debug_wb_have_inst,
    input  logic [31:0]              debug_wb_pc,
    input  logic                     debug_wb_ena,
    input  logic [4:0]               debug_wb_reg,
    input  logic [31:0]              debug_wb_value,
    input  logic                     arm,
    input  logic                     trig_en,
    input  logic [31:0]              trig_pc,
    input  logic [$clog2(DEPTH)-1:0] post_cnt,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [31:0]              rd_pc,
    output logic [4:0]               rd_reg,
    output logic [31:0]              rd_value
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    trace_state_t state_q, state_d;

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt_q;
    logic             ovf_q;
    logic [AW-1:0]    post_lat;
    logic [AW-1:0]    post_ctr;
    logic             rec, hit, do_rec, pop;
    logic [ENTRY_W-1:0] wr_entry, rd_entry;

    assign rec = debug_wb_have_inst && debug_wb_ena &&
                 !((FILTER_X0 != 0) && (debug_wb_reg == 5'd0));
    assign hit = debug_wb_have_inst && trig_en &&
                 (debug_wb_pc == trig_pc);

    assign do_rec = !arm && rec &&
                    ((state_q == ST_ARMED) || (state_q == ST_POST));
    assign pop    = !arm && rd_valid && rd_ready;

    assign wr_entry = {debug_wb_pc, debug_wb_reg, debug_wb_value};

    trace_ram #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (do_rec),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = ST_ARMED;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_ARMED: begin
                    if (hit) begin
                        state_d = (post_lat == '0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (rec && (post_ctr == AW'(1))) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Empty buffer, or the last entry leaving, ends the drain.
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else if (pop && (cnt_q == (AW+1)'(1))) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_valid = (state_q == ST_DONE) && (cnt_q != '0);
        rd_pc    = '0;
        rd_reg   = '0;
        rd_value = '0;
        if (rd_valid) begin
            rd_pc    = rd_entry[PC_LSB +: PC_W];
            rd_reg   = rd_entry[REG_LSB +: REG_W];
            rd_value = rd_entry[VAL_LSB +: VAL_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            post_lat <= '0;
            post_ctr <= '0;
        end else if (arm) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            post_lat <= post_cnt;
            post_ctr <= '0;
        end else begin
            if (do_rec) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (cnt_q == FULL) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    ovf_q  <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + (AW+1)'(1);
                end
            end
            if ((state_q == ST_ARMED) && hit && (post_lat != '0)) begin
                post_ctr <= post_lat;
            end else if ((state_q == ST_POST) && rec) begin
                post_ctr <= post_ctr - AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                cnt_q  <= cnt_q - (AW+1)'(1);
            end
        end
    end

    assign state    = state_q;
    assign count    = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_wb_trace_recorder.sv
// Directed bench for wb_trace_recorder (DEPTH 16, x0 filtered).
// Expected values are hand-derived constants per step.
module tb_wb_trace_recorder;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        have_inst = 1'b0;
    logic [31:0] pc = '0;
    logic        ena = 1'b0;
    logic [4:0]  rg = '0;
    logic [31:0] val = '0;
    logic        arm = 1'b0;
    logic        trig_en = 1'b0;
    logic [31:0] trig_pc = '0;
    logic [3:0]  post_cnt = '0;
    logic [1:0]  state;
    logic [4:0]  count;
    logic        overflow;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_pc;
    logic [4:0]  rd_reg;
    logic [31:0] rd_value;

    int n_assert = 0;
    int n_fail = 0;

    wb_trace_recorder #(.DEPTH(DEPTH), .FILTER_X0(1)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .debug_wb_have_inst (have_inst),
        .debug_wb_pc        (pc),
        .debug_wb_ena       (ena),
        .debug_wb_reg       (rg),
        .debug_wb_value     (val),
        .arm                (arm),
        .trig_en            (trig_en),
        .trig_pc            (trig_pc),
        .post_cnt           (post_cnt),
        .state              (state),
        .count              (count),
        .overflow           (overflow),
        .rd_valid           (rd_valid),
        .rd_ready           (rd_ready),
        .rd_pc              (rd_pc),
        .rd_reg             (rd_reg),
        .rd_value           (rd_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] obs,
                       input logic [39:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic [31:0] p, input logic e,
                      input logic [4:0] r, input logic [31:0] v);
        have_inst = 1'b1;
        pc = p;
        ena = e;
        rg = r;
        val = v;
        step();
        have_inst = 1'b0;
        ena = 1'b0;
    endtask

    task automatic do_arm(input logic te, input logic [31:0] tp,
                          input logic [3:0] pcnt);
        arm = 1'b1;
        trig_en = te;
        trig_pc = tp;
        post_cnt = pcnt;
        step();
        arm = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        rd_ready = 1'b1;
        for (int i = 0; i < max_cycles && state != 2'd0; i++) begin
            step();
        end
        rd_ready = 1'b0;
        chk("drain_idle", 40'(state), 40'd0);
    endtask

    initial begin
        #2;
        chk("rst_state", 40'(state), 40'd0);
        chk("rst_count", 40'(count), 40'd0);
        chk("rst_valid", 40'(rd_valid), 40'd0);
        chk("rst_ovf", 40'(overflow), 40'd0);
        #10;
        rst_n = 1'b1;
        step();

        // Events without arm are ignored
        for (int i = 0; i < 5; i++) begin
            ev(32'(4 * i), 1'b1, 5'(i + 1), 32'(i));
        end
        chk("idle_state", 40'(state), 40'd0);
        chk("idle_count", 40'(count), 40'd0);
        chk("idle_valid", 40'(rd_valid), 40'd0);

        // Trigger at 0x10 with two post events
        do_arm(1'b1, 32'h10, 4'd2);
        chk("arm_state", 40'(state), 40'd1);
        for (int i = 0; i < 8; i++) begin
            ev(32'(4 * i), 1'b1, 5'(i + 1), 32'(4 * i + 1));
            if (i == 4) chk("post_state", 40'(state), 40'd2);
        end
        chk("t2_state", 40'(state), 40'd3);
        chk("t2_count", 40'(count), 40'd7);
        chk("t2_ovf", 40'(overflow), 40'd0);
        rd_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            chk("t2_valid", 40'(rd_valid), 40'd1);
            chk("t2_pc", 40'(rd_pc), 40'(4 * k));
            chk("t2_reg", 40'(rd_reg), 40'(k + 1));
            chk("t2_val", 40'(rd_value), 40'(4 * k + 1));
            step();
        end
        rd_ready = 1'b0;
        chk("t2_idle", 40'(state), 40'd0);
        chk("t2_pc_zero", 40'(rd_pc), 40'd0);

        // Free-running wrap, then re-arm clears it
        do_arm(1'b0, 32'h0, 4'd0);
        for (int i = 1; i <= 20; i++) begin
            ev(32'(4 * i), 1'b1, 5'(i), 32'(i));
        end
        chk("fr_count", 40'(count), 40'd16);
        chk("fr_ovf", 40'(overflow), 40'd1);
        do_arm(1'b1, 32'h100, 4'd0);
        chk("rearm_ovf", 40'(overflow), 40'd0);
        ev(32'h100, 1'b1, 5'd3, 32'hABC);
        chk("t3a_state", 40'(state), 40'd3);
        chk("t3a_count", 40'(count), 40'd1);
        chk("t3a_ovf", 40'(overflow), 40'd0);
        chk("t3a_pc", 40'(rd_pc), 40'h100);
        drain(4);

        // Wrap then trigger on event 21: oldest is event 6
        do_arm(1'b1, 32'h1000, 4'd0);
        for (int i = 1; i <= 20; i++) begin
            ev(32'(4 * i), 1'b1, 5'(i), 32'(i));
        end
        ev(32'h1000, 1'b1, 5'd21, 32'd21);
        chk("t3b_state", 40'(state), 40'd3);
        chk("t3b_count", 40'(count), 40'd16);
        chk("t3b_ovf", 40'(overflow), 40'd1);
        chk("t3b_oldest", 40'(rd_pc), 40'h18);
        chk("t3b_oldval", 40'(rd_value), 40'd6);

        // Backpressure pattern 1,0,0,1
        rd_ready = 1'b1;
        step();
        chk("bp1_count", 40'(count), 40'd15);
        chk("bp1_pc", 40'(rd_pc), 40'h1C);
        rd_ready = 1'b0;
        step();
        chk("bp2_count", 40'(count), 40'd15);
        chk("bp2_pc", 40'(rd_pc), 40'h1C);
        step();
        chk("bp3_pc", 40'(rd_pc), 40'h1C);
        chk("bp3_valid", 40'(rd_valid), 40'd1);
        rd_ready = 1'b1;
        step();
        chk("bp4_count", 40'(count), 40'd14);
        chk("bp4_pc", 40'(rd_pc), 40'h20);
        drain(20);

        // Filtering; trigger on a non-writing instruction
        do_arm(1'b1, 32'h200, 4'd1);
        ev(32'h180, 1'b1, 5'd0, 32'h11);
        ev(32'h184, 1'b0, 5'd5, 32'h22);
        ev(32'h188, 1'b1, 5'd6, 32'h33);
        chk("flt_count", 40'(count), 40'd1);
        ev(32'h200, 1'b0, 5'd7, 32'h44);
        chk("flt_hit", 40'(state), 40'd2);
        chk("flt_count2", 40'(count), 40'd1);
        ev(32'h204, 1'b1, 5'd0, 32'h55);
        chk("flt_x0", 40'(state), 40'd2);
        ev(32'h208, 1'b1, 5'd9, 32'h99);
        chk("flt_done", 40'(state), 40'd3);
        chk("flt_count3", 40'(count), 40'd2);
        chk("flt_pc0", 40'(rd_pc), 40'h188);
        chk("flt_reg0", 40'(rd_reg), 40'd6);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("flt_pc1", 40'(rd_pc), 40'h208);
        chk("flt_reg1", 40'(rd_reg), 40'd9);
        chk("flt_val1", 40'(rd_value), 40'h99);
        drain(4);

        // Entering DONE empty returns to IDLE
        do_arm(1'b1, 32'h240, 4'd0);
        ev(32'h240, 1'b1, 5'd0, 32'h0);
        chk("empty_done", 40'(state), 40'd3);
        chk("empty_valid", 40'(rd_valid), 40'd0);
        step();
        chk("empty_idle", 40'(state), 40'd0);

        // Arm during POST clears and re-arms
        do_arm(1'b1, 32'h300, 4'd5);
        ev(32'h2F0, 1'b1, 5'd1, 32'h1);
        ev(32'h2F4, 1'b1, 5'd2, 32'h2);
        ev(32'h300, 1'b1, 5'd3, 32'h3);
        chk("p_state", 40'(state), 40'd2);
        chk("p_count", 40'(count), 40'd3);
        do_arm(1'b1, 32'h400, 4'd0);
        chk("rearm_state", 40'(state), 40'd1);
        chk("rearm_count", 40'(count), 40'd0);

        // Arm beats pop in DONE
        ev(32'h400, 1'b1, 5'd4, 32'h4);
        chk("d_count", 40'(count), 40'd1);
        rd_ready = 1'b1;
        do_arm(1'b1, 32'h500, 4'd0);
        rd_ready = 1'b0;
        chk("armpop_state", 40'(state), 40'd1);
        chk("armpop_count", 40'(count), 40'd0);
        ev(32'h500, 1'b1, 5'd5, 32'h5);
        chk("d2_state", 40'(state), 40'd3);

        // Asynchronous reset mid-DONE
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_state", 40'(state), 40'd0);
        chk("ar_count", 40'(count), 40'd0);
        chk("ar_valid", 40'(rd_valid), 40'd0);
        chk("ar_pc", 40'(rd_pc), 40'd0);
        chk("ar_ovf", 40'(overflow), 40'd0);
        #10;
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
